// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the core data, core instruction and host ports.
// Fixed priority dmem > imem > host, with a starvation counter that promotes the host.
module mem_port_arbiter #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned HOST_MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            dmem_req_valid,
    output logic            dmem_req_ready,
    input  logic [XLEN-1:0] dmem_req_addr,
    input  logic [XLEN-1:0] dmem_req_data,
    input  logic            dmem_req_fcn,
    input  logic [2:0]      dmem_req_typ,
    output logic            dmem_resp_valid,
    output logic [XLEN-1:0] dmem_resp_data,

    input  logic            imem_req_valid,
    output logic            imem_req_ready,
    input  logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_fcn,
    input  logic [2:0]      imem_req_typ,
    output logic            imem_resp_valid,
    output logic [XLEN-1:0] imem_resp_data,

    input  logic            host_req_valid,
    output logic            host_req_ready,
    input  logic [XLEN-1:0] host_req_addr,
    input  logic [XLEN-1:0] host_req_data,
    input  logic            host_req_fcn,
    input  logic [2:0]      host_req_typ,
    output logic            host_resp_valid,
    output logic [XLEN-1:0] host_resp_data,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_data,
    output logic            mem_req_fcn,
    output logic [2:0]      mem_req_typ,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(HOST_MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_I, OWN_H} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              grant;
    logic [WAIT_W-1:0]   host_wait_q, host_wait_d;
    logic                resp_hit;

    // State, owner and host starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            host_wait_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            host_wait_q <= host_wait_d;
        end
    end

    // Arbitration and next-state logic; grant is locked to the owner once issued
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        host_wait_d = host_wait_q;
        grant       = OWN_NONE;
        case (state_q)
            IDLE: begin
                if (host_req_valid && (host_wait_q >= WAIT_LIMIT)) grant = OWN_H;
                else if (dmem_req_valid)                           grant = OWN_D;
                else if (imem_req_valid)                           grant = OWN_I;
                else if (host_req_valid)                           grant = OWN_H;

                if (grant != OWN_NONE) begin
                    owner_d = grant;
                    state_d = mem_req_ready ? RESP : ISSUE;
                    if (grant == OWN_H) begin
                        host_wait_d = '0;
                    end else if (host_req_valid && (host_wait_q != WAIT_SAT)) begin
                        host_wait_d = host_wait_q + WAIT_W'(1);
                    end
                end
            end
            ISSUE: begin
                grant = owner_q;
                if (mem_req_ready) state_d = RESP;
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Request payload mux from the granted port
    always_comb begin
        mem_req_addr = '0;
        mem_req_data = '0;
        mem_req_fcn  = 1'b0;
        mem_req_typ  = 3'b000;
        case (grant)
            OWN_D: begin
                mem_req_addr = dmem_req_addr;
                mem_req_data = dmem_req_data;
                mem_req_fcn  = dmem_req_fcn;
                mem_req_typ  = dmem_req_typ;
            end
            OWN_I: begin
                mem_req_addr = imem_req_addr;
                mem_req_fcn  = imem_req_fcn;
                mem_req_typ  = imem_req_typ;
            end
            OWN_H: begin
                mem_req_addr = host_req_addr;
                mem_req_data = host_req_data;
                mem_req_fcn  = host_req_fcn;
                mem_req_typ  = host_req_typ;
            end
            default: ;
        endcase
    end

    assign mem_req_valid  = (grant != OWN_NONE) && !rst;
    assign dmem_req_ready = (grant == OWN_D) && mem_req_ready && !rst;
    assign imem_req_ready = (grant == OWN_I) && mem_req_ready && !rst;
    assign host_req_ready = (grant == OWN_H) && mem_req_ready && !rst;

    // Responses outside RESP are strays and are dropped
    assign resp_hit        = mem_resp_valid && (state_q == RESP) && !rst;
    assign dmem_resp_valid = resp_hit && (owner_q == OWN_D);
    assign imem_resp_valid = resp_hit && (owner_q == OWN_I);
    assign host_resp_valid = resp_hit && (owner_q == OWN_H);

    assign dmem_resp_data = mem_resp_data;
    assign imem_resp_data = mem_resp_data;
    assign host_resp_data = mem_resp_data;

endmodule
